instr_prefetch: RTL and testbench
=================================

Name: instr_prefetch

Overview:
- Instruction fetch and prefetch stage that sits directly upstream of the cpu core and drives its 12-bit instruction_bus.
- Generates sequential 8-bit fetch addresses and requests words from instruction memory using a req/ack handshake.
- Buffers fetched words in a small FIFO and presents them to the core with a valid/ready handshake.
- Supports a branch redirect that flushes the FIFO and restarts fetch at a new address.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- IW, 12, instruction width in bits; matches the cpu instruction_bus.
- AW, 8, instruction address width; the PC wraps modulo 2^AW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  AW  fetch address; held stable while imem_req is high.
- imem_ack  input  1  memory accepts the request; imem_data is valid in the same cycle.
- imem_data  input  IW  instruction word returned by memory.
- instruction_bus  output  IW  instruction at the FIFO head, to the cpu.
- instr_valid  output  1  instruction_bus holds a valid instruction.
- instr_ready  input  1  cpu consumes the head when instr_valid is also high.
- fetch_pc  output  AW  address of the instruction currently on instruction_bus.
- branch_en  input  1  redirect request, one cycle wide.
- branch_addr  input  AW  redirect target address.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - imem_req=0, imem_addr=0, instruction_bus=0, instr_valid=0, fetch_pc=0.
  - FIFO emptied, next-PC register set to 0, FSM to IDLE.
  - Reset asserted mid-request abandons the request; any later imem_ack is ignored.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE:
    - If count < DEPTH and branch_en=0: drive imem_req=1, imem_addr=pc, go to WAIT.
    - Otherwise imem_req=0.
    - The first request is issued in the first cycle after reset release.
  - WAIT:
    - imem_req stays 1 with imem_addr unchanged until imem_ack.
    - On ack: push {imem_addr, imem_data}, pc <= pc+1 (255 wraps to 0), return to IDLE.
    - Next request is issued the cycle after ack, so at most one request is outstanding and throughput is 1 word per 2 cycles.
  - DISCARD:
    - Entered when branch_en arrives while in WAIT without ack in that cycle.
    - imem_req stays high with the old address until ack; the returned data is dropped and pc is not incremented; then go to IDLE.
- Capacity: a request is issued only when count < DEPTH, counting occupancy after any pop in the current cycle. An ack therefore never overflows the FIFO.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Latency: data acked in cycle N appears with instr_valid=1 in cycle N+1 if the FIFO was empty.
- Empty FIFO: instr_valid=0 and instruction_bus holds its last value, or 0 after reset.
- Branch (branch_en=1), highest priority:
  - FIFO flushed, instr_valid=0 next cycle, pc <= branch_addr.
  - A pop in the same cycle is treated as consumed, then the flush applies.
  - Ack in the same cycle as branch_en: the data is dropped and the FSM goes to IDLE.
  - Branch during DISCARD: pc updates to the newest branch_addr and the FSM stays in DISCARD.
  - The next request, at branch_addr, is issued the cycle after the FSM returns to IDLE.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and imem_ack=1 (not discarding, no branch), imem_data drives instruction_bus and instr_valid=1 combinationally in the same cycle, with fetch_pc=imem_addr.
  - If instr_ready=1 in that cycle, the word is not written into the FIFO.
  - Zero-cycle fetch-to-issue latency.
- Not defined: all outputs are registered and the latency is as specified above (1 cycle).

Test Plan:
- Reset/startup: rst_n low for 2 cycles, memory acks after 1 wait cycle with data = 0x100 + addr → first imem_addr=0x00; instruction_bus=0x100, 0x101, 0x102 with fetch_pc=0,1,2; instr_valid=0 during reset.
- Backpressure: instr_ready=0, immediate acks → exactly 4 words fetched (addr 0–3), imem_req stays 0 afterwards; instr_ready=1 → fetch resumes at addr 4 with no loss or duplication.
- Wrap: branch to 0xFE, then stream → fetch_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Branch during outstanding request: request at addr 0x05, ack delayed 3 cycles, branch_en with 0x40 in the cycle after the request → 0x05 data dropped, FIFO empty, next imem_addr=0x40, first valid instruction has fetch_pc=0x40.
- Simultaneous events: branch_en together with imem_ack and a pop → acked data dropped, pop accepted, instr_valid=0 next cycle, next request to branch_addr.
- Mid-operation reset: rst_n low while in WAIT → next cycle imem_req=0 and instr_valid=0; a stale ack is ignored; fetch restarts at 0x00.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: req/ack fetch into a small FIFO feeding the core.
// Define PREFETCH_BYPASS_EN for zero-latency forwarding of acked words.
module instr_prefetch #(
  parameter int DEPTH = 4,
  parameter int IW    = 12,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instruction_bus,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] fetch_pc,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             req_q, req_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [IW-1:0]    bus_q, bus_d;
  logic [AW-1:0]    opc_q, opc_d;
  logic [AW+IW-1:0] mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             fifo_valid;
  logic             byp_take;
  logic [PW:0]      cnt_pop;
  logic [AW+IW-1:0] wdata;
  logic [AW+IW-1:0] head_d;

  assign fifo_valid = (cnt_q != '0);
  assign wdata      = {addr_q, imem_data};

`ifdef PREFETCH_BYPASS_EN
  logic byp;
  assign byp = (state_q == S_WAIT) && imem_ack
               && !branch_en && !fifo_valid;
  assign byp_take = byp && instr_ready;
  assign instruction_bus = byp ? imem_data : bus_q;
  assign fetch_pc        = byp ? addr_q : opc_q;
  assign instr_valid     = byp || fifo_valid;
`else
  assign byp_take        = 1'b0;
  assign instruction_bus = bus_q;
  assign fetch_pc        = opc_q;
  assign instr_valid     = fifo_valid;
`endif

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    pop     = fifo_valid && instr_ready;
    cnt_pop = cnt_q - (PW+1)'(pop);
    case (state_q)
      S_IDLE: begin
        if (branch_en) begin
          pc_d = branch_addr;
        end else if (cnt_pop < FULL) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_en) begin
          pc_d = branch_addr;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISC;
          end
        end else if (imem_ack) begin
          push    = !byp_take;
          pc_d    = pc_q + AW'(1);
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DISC: begin
        // stale request: wait out its ack, drop the word
        if (branch_en) pc_d = branch_addr;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (branch_en) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PW'(pop);
      wr_d  = wr_q + PW'(push);
      cnt_d = cnt_pop + (PW+1)'(push);
    end

    // head after this edge: the incoming word if the FIFO drains to it
    head_d = (cnt_pop == '0) ? wdata : mem_q[rd_d];
    bus_d  = bus_q;
    opc_d  = opc_q;
    if (cnt_d != '0) begin
      bus_d = head_d[IW-1:0];
      opc_d = head_d[IW +: AW];
    end else if (byp_take) begin
      bus_d = imem_data;
      opc_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      opc_q   <= opc_d;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: random memory/core timing against a
// queue-based model of the fetched instruction stream.
module tb_instr_prefetch;

  localparam int DEPTH = 4;
  localparam int IW    = 12;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instruction_bus;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] fetch_pc;
  logic          branch_en;
  logic [AW-1:0] branch_addr;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .instruction_bus(instruction_bus),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_pc(fetch_pc),
    .branch_en(branch_en),
    .branch_addr(branch_addr)
  );

  int total = 0;
  int bad   = 0;

  // model: addresses the core should see, in order
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_fetch;
  bit            m_stale;
  logic [IW-1:0] m_last_bus;
  logic [AW-1:0] m_last_pc;
  int            n_acc;

  bit            p_req;
  bit            p_valid;
  logic [AW-1:0] p_addr;
  logic [AW-1:0] p_pc;

  int dly_min = 1;
  int dly_max = 1;
  int cur_dly = 0;
  int wait_cnt = 0;
  int rdy_pct = 100;

  logic [AW-1:0] got_pc[$];

  function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
    return IW'(a) + 12'h100;
  endfunction

  task step();
    logic [AW-1:0] h;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_q.delete();
      m_fetch    = '0;
      m_stale    = 1'b0;
      m_last_bus = '0;
      m_last_pc  = '0;
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL rst_req: got=%0b want=0", imem_req);
      end
    end else begin
      if (p_valid && instr_ready) begin
        got_pc.push_back(p_pc);
        if (m_q.size() > 0) h = m_q.pop_front();
      end
      if (branch_en) begin
        m_q.delete();
        m_fetch = branch_addr;
        m_stale = p_req && !imem_ack;
      end else if (p_req && imem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          total++;
          if (p_addr !== m_fetch) begin
            bad++;
            $display("FAIL ack_addr: got=%h want=%h", p_addr, m_fetch);
          end
          total++;
          if (m_q.size() >= DEPTH) begin
            bad++;
            $display("FAIL overflow: got=%0d want<%0d", m_q.size(), DEPTH);
          end
          m_q.push_back(m_fetch);
          m_fetch = m_fetch + 8'd1;
          n_acc++;
        end
      end
      if (p_req && !imem_ack) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          bad++;
          $display("FAIL req_hold: got=%0b/%h want=1/%h",
                   imem_req, imem_addr, p_addr);
        end
      end
    end
    total++;
    if (instr_valid !== (m_q.size() != 0)) begin
      bad++;
      $display("FAIL valid: got=%0b want=%0b", instr_valid, m_q.size() != 0);
    end
    if (m_q.size() != 0) begin
      m_last_pc  = m_q[0];
      m_last_bus = mem_word(m_q[0]);
    end
    total++;
    if (instruction_bus !== m_last_bus || fetch_pc !== m_last_pc) begin
      bad++;
      $display("FAIL head: got=%h@%h want=%h@%h",
               instruction_bus, fetch_pc, m_last_bus, m_last_pc);
    end
    if (imem_req && !m_stale) begin
      total++;
      if (imem_addr !== m_fetch) begin
        bad++;
        $display("FAIL req_addr: got=%h want=%h", imem_addr, m_fetch);
      end
    end
    p_req   = imem_req;
    p_valid = instr_valid;
    p_addr  = imem_addr;
    p_pc    = fetch_pc;
    branch_en   = 1'b0;
    instr_ready = (int'($urandom_range(99)) < rdy_pct);
    if (imem_req) begin
      if (wait_cnt == 0) cur_dly = int'($urandom_range(dly_max, dly_min));
      imem_ack = (wait_cnt >= cur_dly);
      wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    imem_data = mem_word(imem_addr);
  endtask

  task branch_to(input logic [AW-1:0] a);
    branch_en   = 1'b1;
    branch_addr = a;
    step();
  endtask

  task test_reset();
    rst_n = 1'b0;
    branch_en = 1'b0;
    branch_addr = '0;
    instr_ready = 1'b1;
    imem_ack = 1'b0;
    imem_data = '0;
    dly_min = 1;
    dly_max = 1;
    rdy_pct = 100;
    step();
    step();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 8'h00
        || instruction_bus !== 12'h000 || fetch_pc !== 8'h00) begin
      bad++;
      $display("FAIL reset: got req=%0b v=%0b a=%h bus=%h pc=%h want 0",
               imem_req, instr_valid, imem_addr, instruction_bus, fetch_pc);
    end
    rst_n = 1'b1;
    got_pc.delete();
    for (int i = 0; i < 10 && !imem_req; i++) step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL first_req: got=%0b@%h want=1@00", imem_req, imem_addr);
    end
    for (int i = 0; i < 40 && got_pc.size() < 3; i++) step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_pc.size() <= k) begin
        bad++;
        $display("FAIL startup_seq: got=none want=%h", k[7:0]);
      end else if (got_pc[k] !== k[7:0]) begin
        bad++;
        $display("FAIL startup_seq: got=%h want=%h", got_pc[k], k[7:0]);
      end
    end
  endtask

  task test_backpressure();
    int n0;
    rdy_pct = 0;
    dly_min = 0;
    dly_max = 0;
    step();
    branch_to(8'h00);
    n0 = n_acc;
    for (int i = 0; i < 24; i++) step();
    total++;
    if (n_acc - n0 != DEPTH) begin
      bad++;
      $display("FAIL bp_count: got=%0d want=%0d", n_acc - n0, DEPTH);
    end
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || fetch_pc !== 8'h00) begin
      bad++;
      $display("FAIL bp_idle: got req=%0b v=%0b pc=%h want 0/1/00",
               imem_req, instr_valid, fetch_pc);
    end
    rdy_pct = 100;
    step();
    got_pc.delete();
    for (int i = 0; i < 60 && got_pc.size() < 8; i++) step();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got_pc.size() <= k) begin
        bad++;
        $display("FAIL bp_resume: got=none want=%h", k[7:0]);
      end else if (got_pc[k] !== k[7:0]) begin
        bad++;
        $display("FAIL bp_resume: got=%h want=%h", got_pc[k], k[7:0]);
      end
    end
  endtask

  task test_wrap();
    logic [AW-1:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rdy_pct = 100;
    dly_min = 0;
    dly_max = 2;
    branch_to(8'hFE);
    got_pc.delete();
    for (int i = 0; i < 60 && got_pc.size() < 4; i++) step();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got_pc.size() <= k) begin
        bad++;
        $display("FAIL wrap: got=none want=%h", exp_pc[k]);
      end else if (got_pc[k] !== exp_pc[k]) begin
        bad++;
        $display("FAIL wrap: got=%h want=%h", got_pc[k], exp_pc[k]);
      end
    end
  endtask

  task test_branch_outstanding();
    rdy_pct = 100;
    dly_min = 3;
    dly_max = 3;
    branch_to(8'h05);
    for (int i = 0; i < 20 && !(imem_req && imem_addr === 8'h05); i++)
      step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
      bad++;
      $display("FAIL bo_req: got=%0b@%h want=1@05", imem_req, imem_addr);
    end
    step();
    got_pc.delete();
    branch_to(8'h40);
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h05) begin
      bad++;
      $display("FAIL bo_discard: got v=%0b req=%0b a=%h want 0/1/05",
               instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 40 && got_pc.size() < 1; i++) step();
    total++;
    if (got_pc.size() < 1 || got_pc[0] !== 8'h40) begin
      bad++;
      $display("FAIL bo_first: got=%h want=40",
               got_pc.size() > 0 ? got_pc[0] : 8'hxx);
    end
  endtask

  task test_simultaneous();
    int n0;
    rdy_pct = 0;
    dly_min = 0;
    dly_max = 0;
    step();
    branch_to(8'h10);
    for (int i = 0; i < 40 && !(m_q.size() >= 1 && imem_req && imem_ack); i++)
      step();
    n0 = got_pc.size();
    instr_ready = 1'b1;
    rdy_pct = 100;
    branch_to(8'h20);
    total++;
    if (got_pc.size() != n0 + 1 || got_pc[got_pc.size()-1] !== 8'h10) begin
      bad++;
      $display("FAIL sim_pop: got=%0d pops want=1 of 10", got_pc.size() - n0);
    end
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL sim_flush: got=%0b want=0", instr_valid);
    end
    for (int i = 0; i < 10 && !imem_req; i++) step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin
      bad++;
      $display("FAIL sim_next: got=%0b@%h want=1@20", imem_req, imem_addr);
    end
  endtask

  task test_mid_reset();
    rdy_pct = 50;
    dly_min = 3;
    dly_max = 3;
    for (int i = 0; i < 20 && !(imem_req && !imem_ack); i++) step();
    rst_n = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL mr_clear: got req=%0b v=%0b want 0/0",
               imem_req, instr_valid);
    end
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_data = 12'hABC;
    step();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL mr_stale: got=%0b want=0", instr_valid);
    end
    got_pc.delete();
    rdy_pct = 100;
    dly_min = 0;
    dly_max = 1;
    for (int i = 0; i < 40 && got_pc.size() < 2; i++) step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got_pc.size() <= k) begin
        bad++;
        $display("FAIL mr_restart: got=none want=%h", k[7:0]);
      end else if (got_pc[k] !== k[7:0]) begin
        bad++;
        $display("FAIL mr_restart: got=%h want=%h", got_pc[k], k[7:0]);
      end
    end
  endtask

  task test_random();
    int n0;
    int g0;
    rdy_pct = 70;
    dly_min = 0;
    dly_max = 3;
    n0 = n_acc;
    g0 = got_pc.size();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 4) begin
        branch_en   = 1'b1;
        branch_addr = AW'($urandom);
      end
      step();
    end
    total++;
    if (n_acc - n0 < 40 || got_pc.size() - g0 < 40) begin
      bad++;
      $display("FAIL rand_progress: got acc=%0d pops=%0d want>=40",
               n_acc - n0, got_pc.size() - g0);
    end
  endtask

  initial begin
    n_acc   = 0;
    p_req   = 1'b0;
    p_valid = 1'b0;
    p_addr  = '0;
    p_pc    = '0;
    test_reset();
    test_backpressure();
    test_wrap();
    test_branch_outstanding();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
